pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It sustains one transfer per cycle under back-pressure while keeping all outputs registered, so no combinational path runs from input to output. It supports a synchronous flush that loads a parameterised clear value, mirroring the clear semantics of the existing stage flip-flops. It sits between processor pipeline stages, for example IF/ID and ID/EX, where stalls come from downstream `out_ready` and squashes come from branch resolution via `flush`.

---
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a valid/ready handshake and a one-entry skid buffer.
// All handshake outputs are decoded from the state register, so no input reaches an
// output combinationally. A synchronous flush squashes held entries and loads CLR_VALUE.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_m, w_m_d;
  logic [WIDTH-1:0] r_s, w_s_d;
  logic             w_in_xfer, w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign out_data   = r_m;

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (r_state)
      StEmpty: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      StOne: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      StTwo: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      // Illegal encoding: accept nothing, present nothing, recover next edge.
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  // Next-state and data-path selection; flush overrides every handshake update.
  always_comb begin
    w_state_d = r_state;
    w_m_d     = r_m;
    w_s_d     = r_s;
    if (flush) begin
      w_state_d = StEmpty;
      w_m_d     = CLR_VALUE;
      w_s_d     = CLR_VALUE;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_xfer) begin
            w_m_d     = in_data;
            w_state_d = StOne;
          end
        end
        StOne: begin
          if (w_in_xfer && w_out_xfer) begin
            w_m_d = in_data;
          end else if (w_in_xfer) begin
            // Downstream stalled: park the new beat in the skid register.
            w_s_d     = in_data;
            w_state_d = StTwo;
          end else if (w_out_xfer) begin
            w_state_d = StEmpty;
          end
        end
        StTwo: begin
          if (w_out_xfer) begin
            w_m_d     = r_s;
            w_state_d = StOne;
          end
        end
        default: begin
          w_state_d = StEmpty;
        end
      endcase
    end
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StEmpty;
      r_m     <= CLR_VALUE;
      r_s     <= CLR_VALUE;
    end else begin
      r_state <= w_state_d;
      r_m     <= w_m_d;
      r_s     <= w_s_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios followed by random traffic,
// checked by a queue-based model of a two-entry FIFO stage.
module tb_pipe_skid_reg;

  localparam logic [31:0] Clr = 32'hDEAD_BEEF;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;

  pipe_skid_reg #(
    .WIDTH    (32),
    .CLR_VALUE(Clr)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: entries held by the stage, oldest first.
  logic [31:0] q[$];
  logic [31:0] last_front;
  int          n_cmp;
  int          n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard: samples on the falling clock edge, or 1ns after reset asserts.
  initial begin
    n_cmp      = 0;
    n_err      = 0;
    last_front = Clr;
  end

  always begin
    int n;
    @(negedge clock or negedge reset_n);
    if (!reset_n) begin
      #1;
      if (!reset_n) begin
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check("rst_out_data", out_data, Clr);
      end
      q.delete();
      last_front = Clr;
    end else begin
      n = q.size();
      check("out_valid", {31'd0, out_valid}, (n > 0) ? 32'd1 : 32'd0);
      check("in_ready", {31'd0, in_ready}, (n < 2) ? 32'd1 : 32'd0);
      check("occupancy", {30'd0, occupancy}, n);
      check("out_data", out_data, (n > 0) ? q[0] : last_front);
      // Output beat is consumed at the coming edge, even when flush is high.
      if (out_ready && n > 0) void'(q.pop_front());
      if (flush) begin
        q.delete();
        last_front = Clr;
      end else if (in_valid && n < 2) begin
        q.push_back(in_data);
      end
      if (q.size() > 0) last_front = q[0];
    end
  end

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(posedge clock);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    reset_n   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) drive(1'b1, i, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Back-pressure fill and drain.
    drive(1'b1, 32'hA, 1'b1, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush while full, with a same-cycle input that must be dropped.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush together with an output transfer.
    drive(1'b1, 32'h44, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset while full, between clock edges.
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    repeat (4) drive(1'b0, 32'd0, 1'b1, 1'b0);

    @(negedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
